prog_lut: RTL and testbench
===========================

# prog_lut

Programmable, registered look-up-table function unit: the configurable successor to our fixed 5-input decoder-plus-multiplexer logic functions. Instead of wiring one boolean function into mux data inputs, the block holds a 2^SEL_W-entry truth table. The table is loaded serially over a valid/ready handshake, and each select word is then evaluated with a registered result. It sits wherever the design needs a small boolean function of SEL_W signals that firmware or a test bench can change at run time.

## Interface
- SEL_W, 5, number of function inputs; table depth is 2^SEL_W bits; legal range 1..8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cfg_start  input  1  begin a table load; honoured in IDLE and ARMED, ignored in LOAD
- cfg_valid  input  1  cfg_bit is valid
- cfg_bit  input  1  next truth-table bit, index 0 first
- cfg_ready  output  1  high exactly while in LOAD
- cfg_done  output  1  one-cycle pulse on the cycle after the last bit is accepted
- loaded  output  1  table complete and usable
- in_valid  input  1  evaluate in_x this cycle
- in_x  input  SEL_W  select word; bit SEL_W-1 is the MSB
- in_ready  output  1  low while in LOAD; in_valid is ignored when in_ready is low
- out_valid  output  1  result valid
- out_y  output  1  table[in_x]
- out_err  output  1  evaluation requested while loaded=0

## Operation
- Storage: table register of 2^SEL_W bits; out_y = table[in_x].
- Bit counter: SEL_W+1 bits wide.
- FSM states:
  - IDLE: reset state.
  - LOAD: entered from IDLE or ARMED when cfg_start=1. On entry, counter=0 and loaded=0. Table contents are retained until overwritten.
  - ARMED: entered from LOAD after the bit at index 2^SEL_W-1 is accepted.
- Load rules:
  - A bit is accepted when cfg_valid && cfg_ready. It is written to table[counter], then the counter increments.
  - cfg_valid outside LOAD is ignored.
  - cfg_start during LOAD is ignored; the load continues.
- Leaving LOAD: after the final accept, the next cycle shows state=ARMED, loaded=1, cfg_done=1 for one cycle, and cfg_ready=0.
- Evaluation (in_valid && in_ready):
  - If loaded=1: out_valid=1, out_y=table[in_x], out_err=0.
  - If loaded=0 (IDLE): out_valid=1, out_y=0, out_err=1.
- Cycles with no accepted evaluation drive out_valid=0. out_y and out_err hold their last values.
- Reset values: state IDLE; table all 0; counter 0; loaded, cfg_ready, cfg_done, out_valid, out_y and out_err all 0; in_ready 1.
- Reset mid-load: the partial table is discarded to all zeros and the FSM returns to IDLE; a new cfg_start is required.

## Timing
- Evaluation latency: 1 cycle, from the accepting edge to out_valid (2 cycles with PROG_LUT_PIPE_EN).
- Throughput: one evaluation per cycle while in_ready=1.
- Load duration: 2^SEL_W accepted bits, at most one per cycle; cfg_valid gaps stall the load without error.
- cfg_start and in_valid in the same cycle from ARMED:
  - The evaluation is accepted using the old table with loaded=1.
  - The FSM enters LOAD on the same edge.
- in_ready and cfg_ready are combinational from state, not from inputs.
- Evaluations already in the pipeline complete normally after the FSM enters LOAD.

## Configuration
- PROG_LUT_PIPE_EN defined:
  - Adds an input register stage capturing in_valid and in_x.
  - Latency becomes 2 cycles.
  - The table lookup uses the table contents at the second edge.
  - The loaded check is sampled at the first edge.
- PROG_LUT_PIPE_EN undefined: single register stage, latency 1.

## Test plan
- Reset, then in_valid=1 with in_x=5'd3 -> out_valid=1, out_y=0, out_err=1 after 1 cycle; loaded=0; in_ready=1.
- cfg_start, then load 32 bits of 32'h96696996 (5-input parity) with continuous cfg_valid:
  - cfg_done pulses once, 32 cycles after the first accept.
  - Sweeping in_x 0..31 then gives out_y = parity(in_x), with out_err=0 and back-to-back out_valid.
- Load 32'h0000_0001 with random cfg_valid gaps -> only in_x=0 yields out_y=1; cfg_ready stays high until the last accept; in_valid during the load is ignored (no out_valid).
- Assert rst asynchronously after 10 accepted bits -> all outputs are immediately at their reset values and the FSM is in IDLE. A following evaluation gives out_err=1.
- From ARMED, assert cfg_start together with in_valid, in_x=5'd1 -> the old-table result is delivered; the FSM is in LOAD next cycle with loaded=0; cfg_start pulses during LOAD do not restart the counter.
- With PROG_LUT_PIPE_EN and SEL_W=3: load 8'hA5 and sweep in_x 0..7 -> out_y sequence 1,0,1,0,0,1,0,1 at 2-cycle latency.

Source files
------------

// File: rtl/prog_lut.sv
// Programmable registered look-up table: a 2^SEL_W-bit truth table loaded serially, then evaluated per select word.
// Define PROG_LUT_PIPE_EN to add an input register stage (evaluation latency 2 instead of 1).
module prog_lut #(
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             loaded,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_x,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_y,
  output logic             out_err
);

  localparam int DEPTH = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   lut_q;
  logic [SEL_W:0]     count;
  logic               cfg_acc, last_acc, eval_acc;
  logic               ev_valid, ev_loaded;
  logic [SEL_W-1:0]   ev_x;

  // Handshake readies and loaded depend on state only, never on inputs.
  assign cfg_ready = (state == LOAD);
  assign in_ready  = (state != LOAD);
  assign loaded    = (state == ARMED);

  assign cfg_acc  = cfg_valid && cfg_ready;
  assign last_acc = cfg_acc && (count == (SEL_W+1)'(DEPTH - 1));
  assign eval_acc = in_valid && in_ready;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, ARMED: if (cfg_start) state_nxt = LOAD;
      LOAD:        if (last_acc)  state_nxt = ARMED;
      default:     state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the table is a flop vector, so it resets to zero and a reset mid-load discards partial contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_q    <= '0;
      count    <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= last_acc;
      if (state != LOAD && cfg_start) begin
        count <= '0;
      end else if (cfg_acc) begin
        lut_q[count[SEL_W-1:0]] <= cfg_bit;
        count                   <= count + 1'b1;
      end
    end
  end

`ifdef PROG_LUT_PIPE_EN
  logic             s1_valid, s1_loaded;
  logic [SEL_W-1:0] s1_x;

  // loaded is sampled here; the table itself is read one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_loaded <= 1'b0;
      s1_x      <= '0;
    end else begin
      s1_valid <= eval_acc;
      if (eval_acc) begin
        s1_x      <= in_x;
        s1_loaded <= loaded;
      end
    end
  end

  assign ev_valid  = s1_valid;
  assign ev_x      = s1_x;
  assign ev_loaded = s1_loaded;
`else
  assign ev_valid  = eval_acc;
  assign ev_x      = in_x;
  assign ev_loaded = loaded;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= ev_valid;
      if (ev_valid) begin
        out_y   <= ev_loaded & lut_q[ev_x];
        out_err <= ~ev_loaded;
      end
    end
  end

endmodule

// File: tb/tb_prog_lut.sv
// Self-checking bench for prog_lut: vector tables for evaluation sweeps, a scoreboard queue for results,
// and hand-written sequences for load, restart and asynchronous reset corner cases.
module tb_prog_lut;

  localparam int SEL_W = 5;
  localparam int DEPTH = 1 << SEL_W;
`ifdef PROG_LUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_valid, cfg_bit;
  logic             cfg_ready, cfg_done, loaded;
  logic             in_valid;
  logic [SEL_W-1:0] in_x;
  logic             in_ready, out_valid, out_y, out_err;

  prog_lut #(.SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] x;
    logic             y;
    logic             err;
  } vec_t;

  typedef struct {
    logic y;
    logic err;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard side: every out_valid must match the oldest pending expectation, on the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_bit("unexpected out_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_bit("out_y", out_y, e.y);
          check_bit("out_err", out_err, e.err);
          check_int("result cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval(input logic [SEL_W-1:0] x, input logic y, input logic err);
    exp_t e;
    in_valid = 1'b1;
    in_x     = x;
    e.y      = y;
    e.err    = err;
    e.cyc    = cyc + LAT;
    sb.push_back(e);
    tick();
  endtask

  // Serial load of val; with gaps, cfg_valid is randomly dropped and ignored evaluations are offered.
  task automatic load(input logic [DEPTH-1:0] val, input bit gaps, input bit pulses);
    int idx = 0;
    int guard = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int done_base;
    bit ready_ok = 1'b1;
    done_base = done_cnt;
    while (idx < DEPTH && guard < 400) begin
      cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_bit   = val[idx];
      cfg_start = pulses && (idx == 5 || idx == 20);
      in_valid  = gaps;
      in_x      = SEL_W'($urandom);
      if (!cfg_ready) ready_ok = 1'b0;
      if (cfg_valid) begin
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      tick();
      guard++;
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    check_bit("cfg_ready held during load", ready_ok, 1'b1);
    check_int("bits accepted", idx, DEPTH);
    tick();
    check_int("cfg_done pulse count", done_cnt - done_base, 1);
    check_int("cfg_done cycle after last accept", done_cyc, last_cyc + 1);
    if (!gaps) check_int("cfg_done after first accept", done_cyc - first_cyc, DEPTH);
    check_bit("loaded after load", loaded, 1'b1);
    check_bit("cfg_ready after load", cfg_ready, 1'b0);
    check_bit("cfg_done single cycle", cfg_done, 1'b0);
  endtask

  vec_t parity_vecs[DEPTH];
  vec_t one_vecs[6];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      parity_vecs[i].x   = SEL_W'(i);
      parity_vecs[i].y   = ^SEL_W'(i);
      parity_vecs[i].err = 1'b0;
    end
    one_vecs[0] = '{x: 5'd0,  y: 1'b1, err: 1'b0};
    one_vecs[1] = '{x: 5'd1,  y: 1'b0, err: 1'b0};
    one_vecs[2] = '{x: 5'd31, y: 1'b0, err: 1'b0};
    one_vecs[3] = '{x: 5'd16, y: 1'b0, err: 1'b0};
    one_vecs[4] = '{x: 5'd2,  y: 1'b0, err: 1'b0};
    one_vecs[5] = '{x: 5'd0,  y: 1'b1, err: 1'b0};

    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_x = '0;
    tick(); tick();
    rst = 1'b0;

    check_bit("reset loaded", loaded, 1'b0);
    check_bit("reset cfg_ready", cfg_ready, 1'b0);
    check_bit("reset cfg_done", cfg_done, 1'b0);
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset out_y", out_y, 1'b0);
    check_bit("reset out_err", out_err, 1'b0);

    // Evaluation before any load reports an error.
    eval(5'd3, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_bit("idle loaded", loaded, 1'b0);
    check_bit("idle in_ready", in_ready, 1'b1);
    tick();

    // Parity table, continuous load, back-to-back sweep.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_bit("load cfg_ready", cfg_ready, 1'b1);
    check_bit("load in_ready", in_ready, 1'b0);
    check_bit("load loaded", loaded, 1'b0);
    load(32'h96696996, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) eval(parity_vecs[i].x, parity_vecs[i].y, parity_vecs[i].err);
    in_valid = 1'b0;
    tick(); tick();

    // cfg_start together with in_valid from ARMED: old table answers, FSM enters LOAD.
    cfg_start = 1'b1;
    eval(5'd1, 1'b1, 1'b0);
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    check_bit("restart loaded", loaded, 1'b0);
    check_bit("restart cfg_ready", cfg_ready, 1'b1);
    check_bit("restart in_ready", in_ready, 1'b0);
    load(32'h0000_0001, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) eval(one_vecs[i].x, one_vecs[i].y, one_vecs[i].err);
    in_valid = 1'b0;
    tick(); tick();

    // Asynchronous reset after 10 accepted bits.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_bit("async rst loaded", loaded, 1'b0);
    check_bit("async rst cfg_ready", cfg_ready, 1'b0);
    check_bit("async rst in_ready", in_ready, 1'b1);
    check_bit("async rst cfg_done", cfg_done, 1'b0);
    check_bit("async rst out_valid", out_valid, 1'b0);
    check_bit("async rst out_y", out_y, 1'b0);
    check_bit("async rst out_err", out_err, 1'b0);
    tick();
    rst = 1'b0;
    eval(5'd0, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_bit("post-reset loaded", loaded, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    check_int("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
